timer_counter: RTL and testbench

Programmable down-counting timer that sits behind the system bridge as the device responder in the timer address window. It decodes the bridge's word address, write enable and write data into three registers (CTRL, PRESET, COUNT), counts down once per clock, and raises the interrupt request the bridge routes to HWInt[10]. It supports one-shot (mode 0) and auto-reload (mode 1) operation.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/timer_counter.sv | 148 ++++++++++++++
 tb/tb_timer_counter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the bridge-attached down-counting timer: register map, CTRL bit layout, modes, FSM states.
package timer_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'b00;
    localparam logic [1:0] ADDR_PRESET = 2'b01;
    localparam logic [1:0] ADDR_COUNT  = 2'b10;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM       = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } state_e;

endpackage

// File: rtl/timer_counter.sv
// Programmable down-counter with CTRL/PRESET/COUNT registers and level IRQ; auto-reload mode needs TIMER_MODE1_EN.
// Reads are combinational, writes land at the clock edge with We; no backpressure, every access completes in one cycle.
module timer_counter
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:2]  Addr,
    input  logic [31:0] WD,
    input  logic        We,
    output logic [31:0] RD,
    output logic        IntReq
);

    state_e      state_q, state_d;
    logic        en_q, en_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_q, irq_d;
    logic [1:0]  mode_val;
    logic        reload;
    logic        wr_ctrl, wr_preset;

    assign wr_ctrl   = We && (Addr == ADDR_CTRL);
    assign wr_preset = We && (Addr == ADDR_PRESET);

`ifdef TIMER_MODE1_EN
    logic [1:0] mode_q, mode_d;
    logic       unused_wd;
    assign unused_wd = ^WD[31:4];
    assign mode_val  = mode_q;
    assign reload    = (mode_q == MODE_RELOAD);
`else
    logic unused_wd;
    assign unused_wd = ^{WD[31:4], WD[CTRL_MODE_MSB:CTRL_MODE_LSB]};
    assign mode_val  = MODE_ONESHOT;
    assign reload    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        irq_d    = irq_q;
`ifdef TIMER_MODE1_EN
        mode_d   = mode_q;
`endif
        if (wr_preset) begin
            preset_d = WD;
        end
        if (wr_ctrl) begin
            en_d = WD[CTRL_EN];
            im_d = WD[CTRL_IM];
`ifdef TIMER_MODE1_EN
            mode_d = WD[CTRL_MODE_MSB:CTRL_MODE_LSB];
`endif
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_ctrl && WD[CTRL_EN]) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = '0;
                    state_d = ST_INT;
                    irq_d   = 1'b1;
                end
            end
            ST_INT: begin
                // An explicit re-enable in the expiry cycle restarts instead of retiring.
                if (reload || (wr_ctrl && WD[CTRL_EN])) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    if (!wr_ctrl) begin
                        en_d = 1'b0;
                    end
                end
                if (reload) begin
                    irq_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Disabling always wins and freezes COUNT where it stands.
        if (wr_ctrl && !WD[CTRL_EN]) begin
            state_d = ST_IDLE;
            count_d = count_q;
        end
        if (wr_ctrl || wr_preset) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            en_q     <= 1'b0;
            im_q     <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
`ifdef TIMER_MODE1_EN
            mode_q   <= MODE_ONESHOT;
`endif
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
`ifdef TIMER_MODE1_EN
            mode_q   <= mode_d;
`endif
        end
    end

    always_comb begin
        RD = '0;
        case (Addr)
            ADDR_CTRL: begin
                RD[CTRL_EN]                     = en_q;
                RD[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode_val;
                RD[CTRL_IM]                     = im_q;
            end
            ADDR_PRESET: RD = preset_q;
            ADDR_COUNT:  RD = count_q;
            default:     RD = '0;
        endcase
    end

    assign IntReq = irq_q & im_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter; expected reads/IRQ levels are queued when stimulus is driven and popped when sampled.
module tb_timer_counter;
    import timer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:2]  Addr;
    logic [31:0] WD;
    logic        We;
    logic [31:0] RD;
    logic        IntReq;

    localparam logic [1:0] ADDR_RSV = 2'b11;

    timer_counter dut (
        .clk    (clk),
        .reset  (reset),
        .Addr   (Addr),
        .WD     (WD),
        .We     (We),
        .RD     (RD),
        .IntReq (IntReq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [1:0]  addr;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

`ifdef TIMER_MODE1_EN
    int unsigned m1_cnt [12] = '{3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3, 2};
    int unsigned pr_cnt [10] = '{6, 5, 4, 3, 2, 1, 0, 0, 100, 99};
`endif

    task automatic push(input string tag, input logic [1:0] a, input logic [31:0] rd, input logic irq);
        exp_t e;
        e.tag  = tag;
        e.addr = a;
        e.rd   = rd;
        e.irq  = irq;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        n_chk++;
        assert (sb.size() > 0) n_pass++;
        else begin
            n_fail++;
            $error("FAIL sb_underflow: queue size %0d required >0", sb.size());
            return;
        end
        e = sb.pop_front();
        Addr = e.addr;
        #1;
        n_chk++;
        assert (RD === e.rd) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s RD: got %0h expected %0h", e.tag, RD, e.rd);
        end
        n_chk++;
        assert (IntReq === e.irq) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s IntReq: got %b expected %b", e.tag, IntReq, e.irq);
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] a, input logic [31:0] rd, input logic irq);
        push(tag, a, rd, irq);
        pop_check();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        WD   = d;
        We   = 1'b1;
        @(posedge clk);
        #1;
        We = 1'b0;
        WD = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        We    = 1'b0;
        Addr  = '0;
        WD    = '0;
        tick();
        do_reset();

        chk("rst_ctrl",   ADDR_CTRL,   32'h0, 1'b0);
        chk("rst_preset", ADDR_PRESET, 32'h0, 1'b0);
        chk("rst_count",  ADDR_COUNT,  32'h0, 1'b0);
        chk("rst_rsv",    ADDR_RSV,    32'h0, 1'b0);

        wr(ADDR_COUNT, 32'h1234);
        wr(ADDR_RSV, 32'hFFFF);
        chk("ro_count", ADDR_COUNT,  32'h0, 1'b0);
        chk("rsv_rd",   ADDR_RSV,    32'h0, 1'b0);
        chk("rsv_pre",  ADDR_PRESET, 32'h0, 1'b0);
        chk("rsv_ctrl", ADDR_CTRL,   32'h0, 1'b0);

        // One-shot, N=5: IRQ after the sixth edge past the enable, held until cleared.
        wr(ADDR_PRESET, 32'd5);
        chk("pre5", ADDR_PRESET, 32'd5, 1'b0);
        wr(ADDR_CTRL, 32'h9);
        chk("os_load", ADDR_COUNT, 32'd0, 1'b0);
        for (int k = 5; k >= 1; k--) push("os_cnt", ADDR_COUNT, k, 1'b0);
        push("os_exp", ADDR_COUNT, 32'd0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            pop_check();
        end
        tick();
        chk("os_ctrl8", ADDR_CTRL, 32'h8, 1'b1);
        tick();
        tick();
        chk("os_held", ADDR_COUNT, 32'd0, 1'b1);
        wr(ADDR_PRESET, 32'd7);
        chk("os_clr", ADDR_PRESET, 32'd7, 1'b0);

        // PRESET=0 and PRESET=1 both expire after the second edge.
        wr(ADDR_PRESET, 32'd0);
        wr(ADDR_CTRL, 32'h9);
        push("p0_e1", ADDR_COUNT, 32'd0, 1'b0);
        push("p0_e2", ADDR_COUNT, 32'd0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            pop_check();
        end
        tick();
        chk("p0_ctrl8", ADDR_CTRL, 32'h8, 1'b1);
        wr(ADDR_CTRL, 32'h0);
        chk("p0_clr", ADDR_CTRL, 32'h0, 1'b0);

        wr(ADDR_PRESET, 32'd1);
        wr(ADDR_CTRL, 32'h9);
        push("p1_e1", ADDR_COUNT, 32'd1, 1'b0);
        push("p1_e2", ADDR_COUNT, 32'd0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            pop_check();
        end
        wr(ADDR_PRESET, 32'd0);
        chk("p1_clr", ADDR_CTRL, 32'h8, 1'b0);

        // Masked expiry: Enable still self-clears but IntReq never rises.
        wr(ADDR_PRESET, 32'd2);
        wr(ADDR_CTRL, 32'h1);
        push("im0_c2", ADDR_COUNT, 32'd2, 1'b0);
        push("im0_c1", ADDR_COUNT, 32'd1, 1'b0);
        push("im0_c0", ADDR_COUNT, 32'd0, 1'b0);
        push("im0_dis", ADDR_CTRL, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            pop_check();
        end

        // Reset in the middle of a count.
        wr(ADDR_PRESET, 32'd50);
        wr(ADDR_CTRL, 32'h9);
        tick();
        tick();
        tick();
        chk("mid_cnt", ADDR_COUNT, 32'd48, 1'b0);
        do_reset();
        chk("mr_ctrl",   ADDR_CTRL,   32'h0, 1'b0);
        chk("mr_preset", ADDR_PRESET, 32'h0, 1'b0);
        chk("mr_count",  ADDR_COUNT,  32'h0, 1'b0);
        tick();
        tick();
        chk("mr_idle", ADDR_COUNT, 32'h0, 1'b0);

        // Reset while an interrupt is held.
        wr(ADDR_CTRL, 32'h9);
        tick();
        tick();
        chk("ir_set", ADDR_COUNT, 32'd0, 1'b1);
        do_reset();
        chk("ir_gone", ADDR_CTRL, 32'h0, 1'b0);

`ifdef TIMER_MODE1_EN
        wr(ADDR_PRESET, 32'd3);
        wr(ADDR_CTRL, 32'hB);
        chk("m1_ctrl", ADDR_CTRL, 32'hB, 1'b0);
        for (int k = 0; k < 12; k++) push("m1_per", ADDR_COUNT, m1_cnt[k], (k == 3) || (k == 8));
        for (int k = 0; k < 12; k++) begin
            tick();
            pop_check();
        end
        wr(ADDR_CTRL, 32'h0);
        for (int k = 0; k < 6; k++) push("m1_frz", ADDR_COUNT, 32'd2, 1'b0);
        pop_check();
        for (int k = 0; k < 5; k++) begin
            tick();
            pop_check();
        end

        wr(ADDR_PRESET, 32'd10);
        wr(ADDR_CTRL, 32'hB);
        tick();
        tick();
        tick();
        tick();
        chk("pr_c7", ADDR_COUNT, 32'd7, 1'b0);
        wr(ADDR_PRESET, 32'd100);
        for (int k = 0; k < 10; k++) push("pr_seq", ADDR_COUNT, pr_cnt[k], k == 6);
        pop_check();
        for (int k = 0; k < 9; k++) begin
            tick();
            pop_check();
        end
        wr(ADDR_CTRL, 32'h0);
        chk("pr_stop", ADDR_COUNT, 32'd99, 1'b0);
`else
        wr(ADDR_PRESET, 32'd2);
        wr(ADDR_CTRL, 32'hB);
        chk("nm_ctrl9", ADDR_CTRL, 32'h9, 1'b0);
        push("nm_c2", ADDR_COUNT, 32'd2, 1'b0);
        push("nm_c1", ADDR_COUNT, 32'd1, 1'b0);
        push("nm_exp", ADDR_COUNT, 32'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            pop_check();
        end
        tick();
        chk("nm_ctrl8", ADDR_CTRL, 32'h8, 1'b1);
        tick();
        tick();
        tick();
        chk("nm_noreload", ADDR_COUNT, 32'd0, 1'b1);
        wr(ADDR_CTRL, 32'h0);
        chk("nm_clr", ADDR_CTRL, 32'h0, 1'b0);
`endif

        n_chk++;
        assert (sb.size() == 0) n_pass++;
        else begin
            n_fail++;
            $error("FAIL sb_leftover: queue size %0d required 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
